prod_acc_round: RTL and testbench

Downstream accumulate-and-scale stage for the constant-coefficient multipliers (×−83 and siblings). It takes one signed 24-bit product per accepted beat and sums N products per block into a wide accumulator. It then rounds and arithmetic-shifts the sum, saturates it to a signed 16-bit sample, and presents the sample on a valid/ready output register. It sits between the multiplier bank and the 16-bit sample consumer.

---
 rtl/prod_acc_round_if.sv | 23 ++
 rtl/prod_acc_round.sv | 104 ++++++++++
 tb/tb_prod_acc_round.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/prod_acc_round_if.sv
// Handshake bundle between the multiplier bank, the accumulate/round stage and the sample consumer.
interface prod_acc_round_if #(
   parameter int IN_W  = 24,
   parameter int OUT_W = 16
) ();
   logic                    in_valid;
   logic                    in_ready;
   logic signed [IN_W-1:0]  in_data;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [OUT_W-1:0] out_data;
   logic                    out_sat;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_sat
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_sat
   );
endinterface

// File: rtl/prod_acc_round.sv
// Sums N signed products per block, rounds half-up, shifts right by SHIFT and
// saturates to a signed OUT_W sample held in a valid/ready output register.
module prod_acc_round #(
   parameter int N     = 8,
   parameter int IN_W  = 24,
   parameter int ACC_W = 27,
   parameter int SHIFT = 7,
   parameter int OUT_W = 16
) (
   input logic             clk,
   input logic             rst,
   prod_acc_round_if.slave bus
);
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam int RW = ACC_W + 2;
   localparam logic [CW-1:0]        LAST   = CW'(N - 1);
   localparam logic signed [RW-1:0] HALF   = RW'(1 <<< (SHIFT - 1));
   localparam logic signed [RW-1:0] SAT_HI = RW'((1 <<< (OUT_W - 1)) - 1);
   localparam logic signed [RW-1:0] SAT_LO = -SAT_HI - 1;

   typedef enum logic {ST_ACC, ST_STALL} state_t;

   state_t                  state;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic                    out_valid_q, out_valid_d;
   logic signed [OUT_W-1:0] out_data_q, out_data_d;
   logic                    out_sat_q, out_sat_d;

   logic                    last;
   logic                    in_ready;
   logic                    accept;
   logic signed [ACC_W-1:0] in_ext;
   logic signed [ACC_W:0]   sum;
   logic signed [RW-1:0]    rnd;
   logic signed [RW-1:0]    r;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q       <= '0;
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sat_q   <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sat_q   <= out_sat_d;
      end
   end

   always_comb begin
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sat_d   = out_sat_q;

      last  = (cnt_q == LAST);
      // STALL is fully decoded from the held count, output occupancy and out_ready.
      state = (last && out_valid_q && !bus.out_ready) ? ST_STALL : ST_ACC;
      in_ready = (state == ST_ACC);
      accept   = bus.in_valid && in_ready;

      in_ext = {{(ACC_W - IN_W){bus.in_data[IN_W-1]}}, bus.in_data};
      sum    = {acc_q[ACC_W-1], acc_q} + {in_ext[ACC_W-1], in_ext};
      rnd    = {sum[ACC_W], sum} + HALF;
      r      = rnd >>> SHIFT;

      if (out_valid_q && bus.out_ready)
         out_valid_d = 1'b0;

      if (accept) begin
         if (cnt_q == '0)
            acc_d = in_ext;
         else
            acc_d = sum[ACC_W-1:0];

         if (last) begin
            cnt_d       = '0;
            out_valid_d = 1'b1;
            if (r > SAT_HI) begin
               out_data_d = SAT_HI[OUT_W-1:0];
               out_sat_d  = 1'b1;
            end else if (r < SAT_LO) begin
               out_data_d = SAT_LO[OUT_W-1:0];
               out_sat_d  = 1'b1;
            end else begin
               out_data_d = r[OUT_W-1:0];
               out_sat_d  = 1'b0;
            end
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_sat   = out_sat_q;
endmodule

// File: tb/tb_prod_acc_round.sv
// Directed table-driven bench for prod_acc_round plus backpressure and reset sequences.
module tb_prod_acc_round;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   prod_acc_round_if #(.IN_W(24), .OUT_W(16)) bus ();

   prod_acc_round #(.N(8), .IN_W(24), .ACC_W(27), .SHIFT(7), .OUT_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      string name;
      int    first;
      int    rest;
      int    exp_data;
      int    exp_sat;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Drive one beat from a negedge and wait (bounded) for it to be accepted.
   task automatic send(input int d);
      int t = 0;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 24'(d);
      while (!bus.in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) chk("accept_timeout", 0, 1);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) @(posedge clk);
   endtask

   task automatic send_block(input int first, input int rest, input int gap);
      send(first);
      for (int i = 1; i < 8; i++) begin
         idle(gap);
         send(rest);
      end
   endtask

   // Called right after the accepting edge of the last beat, with out_ready=1.
   task automatic chk_result(input string name, input int exp_d, input int exp_s);
      @(negedge clk);
      chk({name, "_valid"}, int'(bus.out_valid), 1);
      chk({name, "_data"}, int'($signed(bus.out_data)), exp_d);
      chk({name, "_sat"}, int'(bus.out_sat), exp_s);
      @(negedge clk);
      chk({name, "_valid_fall"}, int'(bus.out_valid), 0);
   endtask

   initial begin
      vecs[0] = '{"nominal",  -8300,    -8300,    -519,   0};
      vecs[1] = '{"rnd_p64",  64,       0,        1,      0};
      vecs[2] = '{"rnd_m64",  -64,      0,        0,      0};
      vecs[3] = '{"rnd_m65",  -65,      0,        -1,     0};
      vecs[4] = '{"sat_pos",  8388607,  8388607,  32767,  1};
      vecs[5] = '{"sat_neg",  -8388608, -8388608, -32768, 1};
      vecs[6] = '{"blk_128",  128,      128,      8,      0};

      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_out_valid", int'(bus.out_valid), 0);
      chk("rst_out_data", int'($signed(bus.out_data)), 0);
      chk("rst_out_sat", int'(bus.out_sat), 0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", int'(bus.in_ready), 1);

      for (int v = 0; v < 7; v++) begin
         send_block(vecs[v].first, vecs[v].rest, 0);
         chk_result(vecs[v].name, vecs[v].exp_data, vecs[v].exp_sat);
      end

      // Idle gaps between every beat must not disturb the sum.
      send_block(-8300, -8300, 2);
      chk_result("gaps", -519, 0);

      // Backpressure: second block streams in behind a held result.
      bus.out_ready = 1'b0;
      send_block(-8300, -8300, 0);
      @(negedge clk);
      chk("bp_r1_valid", int'(bus.out_valid), 1);
      chk("bp_r1_data", int'($signed(bus.out_data)), -519);
      for (int i = 1; i < 8; i++) begin
         send(64);
         @(negedge clk);
         chk("bp_r1_hold", int'($signed(bus.out_data)), -519);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = 24'(64);
      chk("bp_stall_ready", int'(bus.in_ready), 0);
      @(negedge clk);
      chk("bp_stall_ready2", int'(bus.in_ready), 0);
      chk("bp_stall_valid", int'(bus.out_valid), 1);
      chk("bp_stall_data", int'($signed(bus.out_data)), -519);
      bus.out_ready = 1'b1;
      #1 chk("bp_release_ready", int'(bus.in_ready), 1);
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      chk("bp_r2_valid", int'(bus.out_valid), 1);
      chk("bp_r2_data", int'($signed(bus.out_data)), 4);
      chk("bp_r2_sat", int'(bus.out_sat), 0);
      @(negedge clk);
      chk("bp_r2_hold", int'($signed(bus.out_data)), 4);
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("bp_r2_fall", int'(bus.out_valid), 0);

      // Reset mid-block discards the partial sum.
      send(1000);
      send(1000);
      send(1000);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_ready", int'(bus.in_ready), 1);
      chk("mid_rst_valid", int'(bus.out_valid), 0);
      send_block(128, 128, 0);
      chk_result("mid_rst", 8, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
